// File: rtl/dram_responder.sv
// Single-port 8-bit word store shared by a priority core port and a
// request/ack host port that is served only on edges the core leaves idle.
module dram_responder #(
    parameter int DEPTH = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_address,
    input  logic [7:0]  i_data,
    input  logic        i_rden,
    input  logic        i_wren,
    output logic [7:0]  o_q,
    input  logic        i_host_req,
    input  logic        i_host_we,
    input  logic [15:0] i_host_addr,
    input  logic [7:0]  i_host_wdata,
    output logic        o_host_ack,
    output logic [7:0]  o_host_rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } host_state_t;

    host_state_t   state;
    host_state_t   state_next;

    logic [7:0]    mem [DEPTH];

    logic          core_access;
    logic          core_in_range;
    logic          host_in_range;
    logic          host_go;
    logic [AW-1:0] core_idx;
    logic [AW-1:0] host_idx;

    assign core_access   = i_rden | i_wren;
    assign core_in_range = {16'd0, i_address}   < 32'(DEPTH);
    assign host_in_range = {16'd0, i_host_addr} < 32'(DEPTH);
    assign core_idx      = i_address[AW-1:0];
    assign host_idx      = i_host_addr[AW-1:0];

    // NOTE: storage has no reset branch; clearing a RAM array would force it into flops.
    always_ff @(posedge i_clk) begin
        if (i_wren && core_in_range) begin
            mem[core_idx] <= i_data;
        end else if (host_go && i_host_we && host_in_range) begin
            mem[host_idx] <= i_host_wdata;
        end
    end

    // NOTE: non-blocking reads sample mem before this edge's write, giving read-old-data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q <= '0;
        end else if (i_rden) begin
            o_q <= core_in_range ? mem[core_idx] : 8'h00;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_host_rdata <= '0;
        end else if (host_go && !i_host_we) begin
            o_host_rdata <= host_in_range ? mem[host_idx] : 8'h00;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        host_go    = 1'b0;
        o_host_ack = 1'b0;
        case (state)
            IDLE: begin
                // Core owns the edge whenever it accesses; the host simply waits.
                if (i_host_req && !core_access) begin
                    host_go    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                o_host_ack = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: core priority, host stall/ack timing,
// out-of-range handling and reset behaviour.
module tb_dram_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] address;
    logic [7:0]  data;
    logic        rden;
    logic        wren;
    logic [7:0]  q;
    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dram_responder #(.DEPTH(4096)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_address    (address),
        .i_data       (data),
        .i_rden       (rden),
        .i_wren       (wren),
        .o_q          (q),
        .i_host_req   (host_req),
        .i_host_we    (host_we),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .o_host_ack   (host_ack),
        .o_host_rdata (host_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_write(input logic [15:0] a, input logic [7:0] d);
        address = a; data = d; wren = 1'b1;
        tick();
        wren = 1'b0;
    endtask

    task automatic core_read(input logic [15:0] a);
        address = a; rden = 1'b1;
        tick();
        rden = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; address = '0; data = '0; rden = 1'b0; wren = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        tick(); tick();
        total_cnt++; if (q !== 8'h00) $display("FAIL reset_q: got %h want 00", q); else pass_cnt++;
        total_cnt++; if (host_rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", host_rdata); else pass_cnt++;
        total_cnt++; if (host_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", host_ack); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_core_rw();
        core_write(16'h0010, 8'hA5);
        core_write(16'h0011, 8'h3C);
        core_read(16'h0010);
        total_cnt++; if (q !== 8'hA5) $display("FAIL core_read_10: got %h want a5", q); else pass_cnt++;
        core_read(16'h0011);
        total_cnt++; if (q !== 8'h3C) $display("FAIL core_read_11: got %h want 3c", q); else pass_cnt++;
        core_write(16'h0010, 8'h00);
        tick();
        total_cnt++; if (q !== 8'h3C) $display("FAIL core_q_hold: got %h want 3c", q); else pass_cnt++;
        core_write(16'h0010, 8'hA5);
    endtask

    task automatic test_read_during_write();
        core_write(16'h0020, 8'h11);
        address = 16'h0020; data = 8'h22; rden = 1'b1; wren = 1'b1;
        tick();
        rden = 1'b0; wren = 1'b0;
        total_cnt++; if (q !== 8'h11) $display("FAIL rdw_old: got %h want 11", q); else pass_cnt++;
        core_read(16'h0020);
        total_cnt++; if (q !== 8'h22) $display("FAIL rdw_new: got %h want 22", q); else pass_cnt++;
    endtask

    task automatic test_host_stall();
        core_write(16'h0030, 8'hC3);
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0030;
        address = 16'h0010; rden = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (host_ack !== 1'b0) $display("FAIL stall_ack_%0d: got %b want 0", i, host_ack); else pass_cnt++;
        end
        rden = 1'b0;
        tick();
        total_cnt++; if (host_ack !== 1'b1) $display("FAIL stall_ack_done: got %b want 1", host_ack); else pass_cnt++;
        total_cnt++; if (host_rdata !== 8'hC3) $display("FAIL stall_rdata: got %h want c3", host_rdata); else pass_cnt++;
        total_cnt++; if (q !== 8'hA5) $display("FAIL stall_q: got %h want a5", q); else pass_cnt++;
        host_req = 1'b0;
        tick();
        total_cnt++; if (host_ack !== 1'b0) $display("FAIL stall_ack_pulse: got %b want 0", host_ack); else pass_cnt++;
        total_cnt++; if (host_rdata !== 8'hC3) $display("FAIL stall_rdata_hold: got %h want c3", host_rdata); else pass_cnt++;
    endtask

    task automatic test_host_write();
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0040; host_wdata = 8'h5A;
        tick();
        total_cnt++; if (host_ack !== 1'b1) $display("FAIL hw_ack: got %b want 1", host_ack); else pass_cnt++;
        total_cnt++; if (q !== 8'hA5) $display("FAIL hw_q_unchanged: got %h want a5", q); else pass_cnt++;
        total_cnt++; if (host_rdata !== 8'hC3) $display("FAIL hw_rdata_unchanged: got %h want c3", host_rdata); else pass_cnt++;
        tick();
        total_cnt++; if (host_ack !== 1'b0) $display("FAIL hw_spacing_gap: got %b want 0", host_ack); else pass_cnt++;
        tick();
        total_cnt++; if (host_ack !== 1'b1) $display("FAIL hw_spacing_reack: got %b want 1", host_ack); else pass_cnt++;
        host_req = 1'b0; host_we = 1'b0;
        tick();
        core_read(16'h0040);
        total_cnt++; if (q !== 8'h5A) $display("FAIL hw_core_readback: got %h want 5a", q); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        core_write(16'h0000, 8'h12);
        core_write(16'h0FFF, 8'h77);
        core_write(16'h0005, 8'h01);
        core_write(16'h1000, 8'hFF);
        core_read(16'h1000);
        total_cnt++; if (q !== 8'h00) $display("FAIL oob_core_read: got %h want 00", q); else pass_cnt++;
        core_read(16'h0000);
        total_cnt++; if (q !== 8'h12) $display("FAIL oob_no_alias: got %h want 12", q); else pass_cnt++;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0FFF;
        tick();
        host_req = 1'b0;
        total_cnt++; if (host_rdata !== 8'h77) $display("FAIL oob_host_top: got %h want 77", host_rdata); else pass_cnt++;
        tick();
        host_req = 1'b1; host_addr = 16'h1000;
        tick();
        host_req = 1'b0;
        total_cnt++; if (host_rdata !== 8'h00) $display("FAIL oob_host_read: got %h want 00", host_rdata); else pass_cnt++;
        tick();
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h2005; host_wdata = 8'hEE;
        tick();
        host_req = 1'b0; host_we = 1'b0;
        tick();
        core_read(16'h0005);
        total_cnt++; if (q !== 8'h01) $display("FAIL oob_host_write: got %h want 01", q); else pass_cnt++;
    endtask

    task automatic test_reset_mid_request();
        // Host request stalled behind the core, then reset lands before any ack.
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0040;
        address = 16'h0010; rden = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        total_cnt++; if (q !== 8'h00) $display("FAIL rst_mid_q: got %h want 00", q); else pass_cnt++;
        total_cnt++; if (host_rdata !== 8'h00) $display("FAIL rst_mid_rdata: got %h want 00", host_rdata); else pass_cnt++;
        rden = 1'b0;
        tick(); tick();
        total_cnt++; if (host_ack !== 1'b0) $display("FAIL rst_mid_ack: got %b want 0", host_ack); else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++; if (host_ack !== 1'b1) $display("FAIL rst_after_ack: got %b want 1", host_ack); else pass_cnt++;
        total_cnt++; if (host_rdata !== 8'h5A) $display("FAIL rst_after_rdata: got %h want 5a", host_rdata); else pass_cnt++;
        host_req = 1'b0;
        tick();
        // Reset during ACK: ack dropped at once, completed write survives.
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0050; host_wdata = 8'h9C;
        tick();
        total_cnt++; if (host_ack !== 1'b1) $display("FAIL rst_ack_pre: got %b want 1", host_ack); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (host_ack !== 1'b0) $display("FAIL rst_ack_drop: got %b want 0", host_ack); else pass_cnt++;
        host_req = 1'b0; host_we = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        core_read(16'h0050);
        total_cnt++; if (q !== 8'h9C) $display("FAIL rst_write_kept: got %h want 9c", q); else pass_cnt++;
        core_read(16'h0010);
        total_cnt++; if (q !== 8'hA5) $display("FAIL rst_mem_kept: got %h want a5", q); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_core_rw();
        test_read_during_write();
        test_host_stall();
        test_host_write();
        test_out_of_range();
        test_reset_mid_request();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4096: number of 8-bit words implemented; legal range 1..65536.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port i_address  input  16  core word address.
REQ-005 SHALL have port i_data  input  8  core write data.
REQ-006 SHALL have port i_rden  input  1  core read enable.
REQ-007 SHALL have port i_wren  input  1  core write enable.
REQ-008 SHALL have port o_q  output  8  core read data, registered.
REQ-009 SHALL have port i_host_req  input  1  host access request, level, held until ack.
REQ-010 SHALL have port i_host_we  input  1  host access type: 1 write, 0 read; stable while req high.
REQ-011 SHALL have port i_host_addr  input  16  host word address; stable while req high.
REQ-012 SHALL have port i_host_wdata  input  8  host write data; stable while req high.
REQ-013 SHALL have port o_host_ack  output  1  one-cycle completion pulse.
REQ-014 SHALL have port o_host_rdata  output  8  host read data; valid in the ack cycle.

Function
REQ-015 SHALL implement DEPTH x 8 single-port storage, shared by the core port and the host port, with exactly one access per clock edge.
REQ-016 Core port SHALL have absolute priority: a core access on a given edge is any edge where i_rden or i_wren is 1.
REQ-017 Core read: o_q SHALL present mem[i_address] from the edge where i_rden=1 (1-cycle latency) and SHALL hold that value until the next core read.
REQ-018 Core write: mem[i_address] SHALL be written with i_data on the edge where i_wren=1.
REQ-019 Core i_rden=1 and i_wren=1 together: the write SHALL take effect, and o_q SHALL return the old (pre-write) contents.
REQ-020 Out of range (address >= DEPTH) on either port: the write SHALL be discarded and the read SHALL return 8'h00.
REQ-021 Host FSM SHALL have two states: IDLE and ACK.
REQ-022 IDLE -> ACK SHALL occur on an edge where i_host_req=1 and the core port is idle; on that edge the host access SHALL be performed (write mem, or capture o_host_rdata).
REQ-023 In IDLE with i_host_req=1 and a core access, the FSM SHALL stay in IDLE (host stalled), and no host access SHALL occur.
REQ-024 ACK SHALL drive o_host_ack=1 and return unconditionally to IDLE on the next edge; minimum host access spacing SHALL be 2 cycles.
REQ-025 i_host_req still 1 during ACK SHALL NOT be served in that cycle; it SHALL be treated as a new request once the FSM is back in IDLE.
REQ-026 o_host_rdata SHALL hold its last value outside ack, and SHALL be unchanged by host writes.
REQ-027 The host port SHALL have no starvation protection: the host waits as long as the core keeps accessing.
REQ-028 o_q SHALL be unaffected by host accesses.

Reset
REQ-029 Assertion of i_rst_n=0 SHALL immediately force o_q=0, o_host_rdata=0, o_host_ack=0, and FSM=IDLE.
REQ-030 Storage contents SHALL NOT be cleared by reset; a host access in flight at reset SHALL be dropped without ack, and its write, if already performed, SHALL remain.
REQ-031 After deassertion, the first edge with a request SHALL be serviced normally.

Verification
REQ-032 Core write addr 0x0010 data 0xA5, then core read 0x0010 -> o_q=0xA5 one cycle after the read edge.
REQ-033 Core rden+wren together at 0x0020 (old 0x11, new 0x22) -> o_q=0x11; a later read of 0x0020 -> o_q=0x22.
REQ-034 Host read request of 0x0030 while the core reads for 3 consecutive cycles -> ack in the cycle after the first core-idle edge, and o_host_rdata equals mem[0x0030].
REQ-035 Host write 0x0040=0x5A with core idle -> ack exactly 1 cycle after the request; a core read of 0x0040 -> o_q=0x5A, with o_q unchanged during the host access.
REQ-036 DEPTH=4096: core write 0x1000=0xFF, then read 0x1000 -> o_q=0x00; host read of 0x0FFF returns its stored value.
REQ-037 Reset asserted mid-host-request (before ack) -> o_host_ack stays 0, outputs read 0, and after release the held request completes with ack.
